spi_transaction_fsm: RTL and testbench

Parametrised control state machine for the SPI slave peripheral, driving the address latch, data memory write, shift-register parallel load and MISO tri-state buffer. It consumes conditioned, edge-detected SPI inputs from the input conditioners and replaces the fixed 8-bit, single-word controller. Address and data widths are generalised, it has a configurable memory read latency and an optional multi-word burst mode. Strobe outputs are single-cycle pulses rather than sticky levels.

---
 rtl/spi_transaction_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_spi_transaction_fsm.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// spi_transaction_fsm
//
// Control state machine for the SPI slave peripheral. It watches conditioned,
// edge-detected SPI inputs and sequences one transaction:
//   header (ADDR_BITS address bits followed by the R/W bit) -> address latch ->
//   either a read (memory wait, shift-register load, shift out with MISO
//   driven) or a write (shift in, then commit to data memory).
// All strobes are single-clk pulses; misoBufferEnable is a level.
//
// Optional feature (compile-time macro SPI_FSM_BURST_EN):
//   defined   - at the end of each word the address latch is advanced and the
//               next word follows, until chip select is released.
//   undefined - a single word per transaction; addressIncrement is tied to 0.
//
// Parameters:
//   ADDR_BITS     address bits per header (header length ADDR_BITS+1)
//   DATA_BITS     data bits per word
//   READ_LATENCY  clk cycles spent waiting between address latch and the
//                 shift-register load (1..15)
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous, active-high
//   sClkPosEdge            one-clk pulse per conditioned SCLK rising edge
//   chipSelectConditioned  conditioned CS, 0 = selected
//   readWriteEnable        R/W bit from the shift register, 1 = read
//   addressWriteEnable     pulse: latch address
//   SRWriteEnable          pulse: parallel-load shift register from memory
//   misoBufferEnable       level: drive MISO
//   DMWriteEnable          pulse: write data memory
//   addressIncrement       pulse: advance address latch (burst only)
// -----------------------------------------------------------------------------
module spi_transaction_fsm #(
  parameter int ADDR_BITS    = 7,
  parameter int DATA_BITS    = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sClkPosEdge,
  input  logic chipSelectConditioned,
  input  logic readWriteEnable,
  output logic addressWriteEnable,
  output logic SRWriteEnable,
  output logic misoBufferEnable,
  output logic DMWriteEnable,
  output logic addressIncrement
);

  localparam int HDR_LEN = ADDR_BITS + 1;
  localparam int MAX_LEN = (HDR_LEN > DATA_BITS) ? HDR_LEN : DATA_BITS;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  // Terminal counts: the transition happens on the edge that would have made
  // the counter reach the full length, so we compare against length-1.
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [3:0]       WAIT_LAST = 4'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    IDLE,
    HEADER,
    DECODE,
    READ_WAIT,
    READ_LOAD,
    READ_SHIFT,
    WRITE_SHIFT,
    WRITE_COMMIT,
    WORD_END,
    DONE
  } state_t;

  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] bit_cnt_reg,  bit_cnt_next;
  logic [3:0]       wait_cnt_reg, wait_cnt_next;
  logic             is_read_reg,  is_read_next;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      is_read_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      is_read_reg  <= is_read_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    is_read_next  = is_read_reg;

    case (state_reg)
      IDLE: begin
        if (!chipSelectConditioned) state_next = HEADER;
      end

      HEADER: begin
        if (sClkPosEdge) begin
          if (bit_cnt_reg == HDR_LAST) state_next = DECODE;
          else                         bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end

      // The R/W bit has just settled into the shift-register LSB; remember it
      // so the word-end state knows which direction a burst continues in.
      DECODE: begin
        is_read_next = readWriteEnable;
        state_next   = readWriteEnable ? READ_WAIT : WRITE_SHIFT;
      end

      READ_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) state_next = READ_LOAD;
        else                           wait_cnt_next = wait_cnt_reg + 1'b1;
      end

      READ_LOAD: begin
        state_next = READ_SHIFT;
      end

      READ_SHIFT: begin
        if (sClkPosEdge) begin
          if (bit_cnt_reg == DATA_LAST) state_next = WORD_END;
          else                          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end

      WRITE_SHIFT: begin
        if (sClkPosEdge) begin
          if (bit_cnt_reg == DATA_LAST) state_next = WRITE_COMMIT;
          else                          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end

      WRITE_COMMIT: begin
        state_next = WORD_END;
      end

      WORD_END: begin
`ifdef SPI_FSM_BURST_EN
        // Next word in the same direction; the address latch handles wrap.
        state_next = is_read_reg ? READ_WAIT : WRITE_SHIFT;
`else
        state_next = DONE;
`endif
      end

      // Stay here, ignoring SCLK, until chip select is released below.
      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Every state entry starts with fresh counters.
    if (state_next != state_reg) begin
      bit_cnt_next  = '0;
      wait_cnt_next = '0;
    end

    // Deselect overrides everything, including an SCLK edge in the same cycle,
    // so an aborted word never reaches the commit state.
    if (chipSelectConditioned) begin
      state_next    = IDLE;
      bit_cnt_next  = '0;
      wait_cnt_next = '0;
      is_read_next  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    addressWriteEnable = (state_reg == DECODE);
    SRWriteEnable      = (state_reg == READ_LOAD);
    DMWriteEnable      = (state_reg == WRITE_COMMIT);
    misoBufferEnable   = (state_reg == READ_LOAD) ||
                         (state_reg == READ_SHIFT) ||
                         ((state_reg == WORD_END) && is_read_reg);
`ifdef SPI_FSM_BURST_EN
    // Only advance the address if the master is still holding CS for the
    // next word.
    addressIncrement   = (state_reg == WORD_END) && !chipSelectConditioned;
`else
    addressIncrement   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_transaction_fsm
//
// Directed bench for spi_transaction_fsm. Two instances: dut (default
// parameters) and dut2 (ADDR_BITS=15, DATA_BITS=16, READ_LATENCY=4). They share
// clk, reset, sClkPosEdge and readWriteEnable; each has its own chip select so
// only one is active at a time. Expectations for burst mode follow the
// SPI_FSM_BURST_EN macro.
// -----------------------------------------------------------------------------
module tb_spi_transaction_fsm;

`ifdef SPI_FSM_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, sclk, rw, cs, cs2;
  logic aw, sr, miso, dm, ai;
  logic aw2, sr2, miso2, dm2, ai2;

  int errors = 0;
  int checks = 0;

  spi_transaction_fsm dut (
    .clk                   (clk),
    .reset                 (reset),
    .sClkPosEdge           (sclk),
    .chipSelectConditioned (cs),
    .readWriteEnable       (rw),
    .addressWriteEnable    (aw),
    .SRWriteEnable         (sr),
    .misoBufferEnable      (miso),
    .DMWriteEnable         (dm),
    .addressIncrement      (ai)
  );

  spi_transaction_fsm #(
    .ADDR_BITS    (15),
    .DATA_BITS    (16),
    .READ_LATENCY (4)
  ) dut2 (
    .clk                   (clk),
    .reset                 (reset),
    .sClkPosEdge           (sclk),
    .chipSelectConditioned (cs2),
    .readWriteEnable       (rw),
    .addressWriteEnable    (aw2),
    .SRWriteEnable         (sr2),
    .misoBufferEnable      (miso2),
    .DMWriteEnable         (dm2),
    .addressIncrement      (ai2)
  );

  // Pulse monitor on dut, sampled on the falling edge.
  int cyc = 0;
  int cnt_aw, cnt_sr, cnt_dm, cnt_ai, cnt_miso;
  int cyc_aw, cyc_sr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (aw)   begin cnt_aw++; cyc_aw = cyc; end
    if (sr)   begin cnt_sr++; cyc_sr = cyc; end
    if (dm)   cnt_dm++;
    if (ai)   cnt_ai++;
    if (miso) cnt_miso++;
  end

  task automatic clr_mon();
    cnt_aw = 0; cnt_sr = 0; cnt_dm = 0; cnt_ai = 0; cnt_miso = 0;
    cyc_aw = 0; cyc_sr = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One SCLK pulse; returns one clk after the counting edge with sclk low.
  task automatic edge_once();
    sclk = 1'b1;
    step();
    sclk = 1'b0;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      edge_once();
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".aw"},   32'(aw),   32'd0);
    chk({tag, ".sr"},   32'(sr),   32'd0);
    chk({tag, ".miso"}, 32'(miso), 32'd0);
    chk({tag, ".dm"},   32'(dm),   32'd0);
    chk({tag, ".ai"},   32'(ai),   32'd0);
  endtask

  task automatic run_write(input string tag);
    clr_mon();
    rw = 1'b0;
    cs = 1'b0;
    step();                                   // IDLE -> HEADER
    edges(7);
    chk({tag, ".aw_early"}, 32'(aw), 32'd0);
    edge_once();                              // 8th header edge -> DECODE
    chk({tag, ".aw_pulse"}, 32'(aw), 32'd1);
    step();                                   // -> WRITE_SHIFT
    chk({tag, ".aw_off"}, 32'(aw), 32'd0);
    edges(7);
    chk({tag, ".dm_early"}, 32'(dm), 32'd0);
    edge_once();                              // 8th data edge -> WRITE_COMMIT
    chk({tag, ".dm_pulse"}, 32'(dm), 32'd1);
    step();                                   // -> WORD_END
    chk({tag, ".dm_off"}, 32'(dm), 32'd0);
    chk({tag, ".ai_wordend"}, 32'(ai), 32'(BURST));
    step();
    // A few SCLK pulses after the word must not produce another commit.
    edges(3);
    chk_idle({tag, ".after"});
    chk({tag, ".cnt_aw"},   32'(cnt_aw),   32'd1);
    chk({tag, ".cnt_dm"},   32'(cnt_dm),   32'd1);
    chk({tag, ".cnt_miso"}, 32'(cnt_miso), 32'd0);
    cs = 1'b1;
    step();
    chk_idle({tag, ".desel"});
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; rw = 1'b0; cs = 1'b1; cs2 = 1'b1;
    clr_mon();
    step(); step();
    chk_idle("reset");
    chk("reset.aw2", 32'(aw2), 32'd0);
    chk("reset.sr2", 32'(sr2), 32'd0);
    reset = 1'b0;
    step();
    chk_idle("post_reset");

    // ---- Single-word write ----
    run_write("wr1");

    // ---- Single-word read ----
    clr_mon();
    cs = 1'b0;
    step();
    rw = 1'b1;
    edges(7);
    edge_once();                              // -> DECODE
    chk("rd.aw_pulse", 32'(aw), 32'd1);
    chk("rd.sr_early", 32'(sr), 32'd0);
    step();                                   // READ_WAIT 1
    chk("rd.wait1_sr",   32'(sr),   32'd0);
    chk("rd.wait1_miso", 32'(miso), 32'd0);
    step();                                   // READ_WAIT 2
    chk("rd.wait2_sr", 32'(sr), 32'd0);
    step();                                   // READ_LOAD
    chk("rd.sr_pulse",  32'(sr),   32'd1);
    chk("rd.load_miso", 32'(miso), 32'd1);
    step();                                   // READ_SHIFT
    chk("rd.sr_off",     32'(sr),   32'd0);
    edges(7);
    chk("rd.shift_miso", 32'(miso), 32'd1);
    edge_once();                              // -> WORD_END
    chk("rd.wordend_miso", 32'(miso), 32'd1);
    chk("rd.wordend_ai",   32'(ai),   32'(BURST));
    step();                                   // DONE (or READ_WAIT in burst)
    chk("rd.done_miso", 32'(miso), 32'd0);
    cs = 1'b1;
    step();
    chk("rd.sr_latency", 32'(cyc_sr - cyc_aw), 32'd3);
    chk("rd.cnt_sr",     32'(cnt_sr),          32'd1);
    chk("rd.cnt_miso",   32'(cnt_miso),        32'd17);
    chk("rd.cnt_dm",     32'(cnt_dm),          32'd0);
    chk_idle("rd.desel");
    rw = 1'b0;

    // ---- Write aborted after 4 data edges ----
    clr_mon();
    cs = 1'b0;
    step();
    edges(8);                                 // header, now WRITE_SHIFT
    edges(4);
    cs = 1'b1;
    sclk = 1'b1;                              // edge together with deselect
    step();
    sclk = 1'b0;
    chk_idle("abort");
    step(); step();
    chk("abort.cnt_dm", 32'(cnt_dm), 32'd0);
    run_write("wr2");

    // ---- Reset during READ_SHIFT ----
    clr_mon();
    cs = 1'b0;
    rw = 1'b1;
    step();
    edges(8);                                 // now READ_WAIT 1
    step(); step(); step();                   // READ_WAIT 2, READ_LOAD, READ_SHIFT
    chk("rst.in_shift_miso", 32'(miso), 32'd1);
    edges(3);
    reset = 1'b1;
    step();
    chk_idle("rst");
    reset = 1'b0;
    step();                                   // IDLE -> HEADER (CS still low)
    edges(7);
    chk("rst.aw_7edges", 32'(aw), 32'd0);
    edge_once();
    chk("rst.aw_8edges", 32'(aw), 32'd1);
    rw = 1'b0;
    cs = 1'b1;
    step();
    chk_idle("rst.desel");

    // ---- Wide instance: 16-bit header, 16-bit data, latency 4 ----
    cs2 = 1'b0;
    rw = 1'b1;
    step();
    edges(15);
    chk("wide.aw_15edges", 32'(aw2), 32'd0);
    edge_once();
    chk("wide.aw_pulse", 32'(aw2), 32'd1);
    step(); step(); step(); step();           // READ_WAIT 1..4
    chk("wide.sr_wait4", 32'(sr2), 32'd0);
    step();                                   // READ_LOAD, 5 cycles after aw
    chk("wide.sr_pulse", 32'(sr2),   32'd1);
    chk("wide.load_miso", 32'(miso2), 32'd1);
    step();
    edges(15);
    chk("wide.miso_15edges", 32'(miso2), 32'd1);
    edge_once();                              // -> WORD_END
    chk("wide.wordend_miso", 32'(miso2), 32'd1);
    step();
    chk("wide.done_miso", 32'(miso2), 32'd0);
    cs2 = 1'b1;
    rw = 1'b0;
    step();
    chk("wide.desel_miso", 32'(miso2), 32'd0);
    chk("wide.desel_dm",   32'(dm2),   32'd0);

    // ---- Three-word write with CS held low ----
    clr_mon();
    cs = 1'b0;
    step();
    edges(8);                                 // header, now WRITE_SHIFT
    for (int w = 0; w < 3; w++) begin
      edges(7);
      edge_once();
      chk($sformatf("burst.dm_w%0d", w), 32'(dm), ((w == 0) || (BURST != 0)) ? 32'd1 : 32'd0);
      step();
      chk($sformatf("burst.ai_w%0d", w), 32'(ai), 32'(BURST));
      step();
    end
    cs = 1'b1;
    step();
    chk("burst.cnt_dm", 32'(cnt_dm), (BURST != 0) ? 32'd3 : 32'd1);
    chk("burst.cnt_ai", 32'(cnt_ai), (BURST != 0) ? 32'd3 : 32'd0);
    chk("burst.cnt_aw", 32'(cnt_aw), 32'd1);
    chk_idle("burst.desel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
